// File: rtl/brq_pkg.sv
// rtl/brq_pkg.sv - shared entry type and sizing helper for the branch issue queue
package brq_pkg;

  // Width of every tag held inside a queue entry; the top is built with ROB_TAG_W equal to this
  localparam int BRQ_TAG_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [31:0]          rs1_val;
    logic [31:0]          rs2_val;
    logic [BRQ_TAG_W-1:0] rs1_tag;
    logic [BRQ_TAG_W-1:0] rs2_tag;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic                 is_branch;
    logic                 is_jump;
    logic                 pred_taken;
    logic [BRQ_TAG_W-1:0] rob_tag;
  } brq_entry_t;

  // Counter width able to hold the values 0..depth
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/brq_select.sv
// rtl/brq_select.sv - combinational oldest-ready picker (lowest index wins)
module brq_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  // Scan from the youngest slot down so the oldest ready entry is the last one written
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/branch_issue_queue.sv
// rtl/branch_issue_queue.sv - collapsing issue queue for the branch unit; optional BRQ_PERF_CNT_EN adds perf counters
module branch_issue_queue
  import brq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ROB_TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_valid_i,
  output logic                         disp_ready_o,
  input  logic [31:0]                  disp_pc_i,
  input  logic [31:0]                  disp_imm_i,
  input  logic [31:0]                  disp_rs1_val_i,
  input  logic [31:0]                  disp_rs2_val_i,
  input  logic                         disp_rs1_rdy_i,
  input  logic                         disp_rs2_rdy_i,
  input  logic [ROB_TAG_W-1:0]         disp_rs1_tag_i,
  input  logic [ROB_TAG_W-1:0]         disp_rs2_tag_i,
  input  logic                         disp_is_branch_i,
  input  logic                         disp_is_jump_i,
  input  logic                         disp_pred_taken_i,
  input  logic [ROB_TAG_W-1:0]         disp_rob_tag_i,
  input  logic                         cdb_valid_i,
  input  logic [ROB_TAG_W-1:0]         cdb_tag_i,
  input  logic [31:0]                  cdb_val_i,
  input  logic                         flush_i,
  output logic                         iss_valid_o,
  output logic [31:0]                  iss_pc_o,
  output logic [31:0]                  iss_imm_o,
  output logic [31:0]                  iss_rs1_val_o,
  output logic [31:0]                  iss_rs2_val_o,
  output logic                         iss_is_branch_o,
  output logic                         iss_is_jump_o,
  output logic                         iss_pred_taken_o,
  output logic [ROB_TAG_W-1:0]         iss_rob_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef BRQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_full_cyc_o,
  output logic [31:0]                  perf_issued_o
`endif
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  brq_entry_t       q      [DEPTH];
  brq_entry_t       q_next [DEPTH];
  brq_entry_t       new_e;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] wr_idx;
  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             do_iss;
  logic             disp_acc;

  assign count_o      = count_q;
  assign disp_ready_o = (count_q < CNT_W'(DEPTH));
  assign disp_acc     = disp_valid_i && disp_ready_o && !flush_i;
  assign do_iss       = (|grant) && !flush_i;
  // An issue this cycle collapses the queue, so the new op lands one slot lower
  assign wr_idx       = count_q - CNT_W'(do_iss);

  // Selection sees only operand readiness registered at the start of the cycle
  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy;
    end
  end

  brq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready (rdy_vec),
    .grant (grant),
    .idx   (sel_idx)
  );

  // Build the incoming entry, capturing a same-cycle CDB broadcast for any waiting operand
  always_comb begin
    new_e            = '0;
    new_e.valid      = 1'b1;
    new_e.pc         = disp_pc_i;
    new_e.imm        = disp_imm_i;
    new_e.rs1_val    = disp_rs1_val_i;
    new_e.rs2_val    = disp_rs2_val_i;
    new_e.rs1_tag    = BRQ_TAG_W'(disp_rs1_tag_i);
    new_e.rs2_tag    = BRQ_TAG_W'(disp_rs2_tag_i);
    new_e.rs1_rdy    = disp_rs1_rdy_i;
    new_e.rs2_rdy    = disp_rs2_rdy_i;
    new_e.is_branch  = disp_is_branch_i;
    new_e.is_jump    = disp_is_jump_i;
    new_e.pred_taken = disp_pred_taken_i;
    new_e.rob_tag    = BRQ_TAG_W'(disp_rob_tag_i);
    if (cdb_valid_i && !disp_rs1_rdy_i && (disp_rs1_tag_i == cdb_tag_i)) begin
      new_e.rs1_val = cdb_val_i;
      new_e.rs1_rdy = 1'b1;
    end
    if (cdb_valid_i && !disp_rs2_rdy_i && (disp_rs2_tag_i == cdb_tag_i)) begin
      new_e.rs2_val = cdb_val_i;
      new_e.rs2_rdy = 1'b1;
    end
  end

  // Next queue contents: collapse over the issued slot, snoop the CDB, append, then flush
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      q_next[i] = q[i];
    end
    if (do_iss) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        seen = seen | grant[i];
        if (seen) begin
          q_next[i] = q[i + 1];
        end
      end
      q_next[DEPTH-1] = '0;
    end
    if (cdb_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_next[i].valid && !q_next[i].rs1_rdy && (q_next[i].rs1_tag == BRQ_TAG_W'(cdb_tag_i))) begin
          q_next[i].rs1_val = cdb_val_i;
          q_next[i].rs1_rdy = 1'b1;
        end
        if (q_next[i].valid && !q_next[i].rs2_rdy && (q_next[i].rs2_tag == BRQ_TAG_W'(cdb_tag_i))) begin
          q_next[i].rs2_val = cdb_val_i;
          q_next[i].rs2_rdy = 1'b1;
        end
      end
    end
    if (disp_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CNT_W'(i)) begin
          q_next[i] = new_e;
        end
      end
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_next[i] = '0;
      end
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_next[i];
      end
      if (flush_i) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CNT_W'(disp_acc) - CNT_W'(do_iss);
      end
    end
  end

  // Registered issue port; data holds between issues, valid is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_o      <= 1'b0;
      iss_pc_o         <= '0;
      iss_imm_o        <= '0;
      iss_rs1_val_o    <= '0;
      iss_rs2_val_o    <= '0;
      iss_is_branch_o  <= 1'b0;
      iss_is_jump_o    <= 1'b0;
      iss_pred_taken_o <= 1'b0;
      iss_rob_tag_o    <= '0;
    end else begin
      iss_valid_o <= do_iss;
      if (do_iss) begin
        iss_pc_o         <= q[sel_idx].pc;
        iss_imm_o        <= q[sel_idx].imm;
        iss_rs1_val_o    <= q[sel_idx].rs1_val;
        iss_rs2_val_o    <= q[sel_idx].rs2_val;
        iss_is_branch_o  <= q[sel_idx].is_branch;
        iss_is_jump_o    <= q[sel_idx].is_jump;
        iss_pred_taken_o <= q[sel_idx].pred_taken;
        iss_rob_tag_o    <= ROB_TAG_W'(q[sel_idx].rob_tag);
      end
    end
  end

`ifdef BRQ_PERF_CNT_EN
  // Full-cycle and issue counters; only reset clears them, flush does not
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cyc_o <= '0;
      perf_issued_o   <= '0;
    end else begin
      if (count_q == CNT_W'(DEPTH)) begin
        perf_full_cyc_o <= perf_full_cyc_o + 32'd1;
      end
      if (iss_valid_o) begin
        perf_issued_o <= perf_issued_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_issue_queue.sv
// tb/tb_branch_issue_queue.sv - self-checking bench for branch_issue_queue against a queue-based model
module tb_branch_issue_queue;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_valid, disp_ready;
  logic [31:0]   disp_pc, disp_imm, disp_v1, disp_v2;
  logic          disp_r1, disp_r2;
  logic [TW-1:0] disp_t1, disp_t2, disp_rob;
  logic          disp_br, disp_jp, disp_pt;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_val;
  logic          flush;
  logic          iss_valid;
  logic [31:0]   iss_pc, iss_imm, iss_v1, iss_v2;
  logic          iss_br, iss_jp, iss_pt;
  logic [TW-1:0] iss_rob;
  logic [2:0]    count;
`ifdef BRQ_PERF_CNT_EN
  logic [31:0]   perf_full, perf_iss;
  logic [31:0]   m_full, m_iss;
`endif

  always #5 clk = ~clk;

  branch_issue_queue #(.DEPTH(DEPTH), .ROB_TAG_W(TW)) dut (
    .clk               (clk),
    .rst               (rst),
    .disp_valid_i      (disp_valid),
    .disp_ready_o      (disp_ready),
    .disp_pc_i         (disp_pc),
    .disp_imm_i        (disp_imm),
    .disp_rs1_val_i    (disp_v1),
    .disp_rs2_val_i    (disp_v2),
    .disp_rs1_rdy_i    (disp_r1),
    .disp_rs2_rdy_i    (disp_r2),
    .disp_rs1_tag_i    (disp_t1),
    .disp_rs2_tag_i    (disp_t2),
    .disp_is_branch_i  (disp_br),
    .disp_is_jump_i    (disp_jp),
    .disp_pred_taken_i (disp_pt),
    .disp_rob_tag_i    (disp_rob),
    .cdb_valid_i       (cdb_valid),
    .cdb_tag_i         (cdb_tag),
    .cdb_val_i         (cdb_val),
    .flush_i           (flush),
    .iss_valid_o       (iss_valid),
    .iss_pc_o          (iss_pc),
    .iss_imm_o         (iss_imm),
    .iss_rs1_val_o     (iss_v1),
    .iss_rs2_val_o     (iss_v2),
    .iss_is_branch_o   (iss_br),
    .iss_is_jump_o     (iss_jp),
    .iss_pred_taken_o  (iss_pt),
    .iss_rob_tag_o     (iss_rob),
    .count_o           (count)
`ifdef BRQ_PERF_CNT_EN
    ,
    .perf_full_cyc_o   (perf_full),
    .perf_issued_o     (perf_iss)
`endif
  );

  typedef struct {
    logic [31:0]   pc, imm, v1, v2;
    logic [TW-1:0] t1, t2, rob;
    bit            r1, r2, br, jp, pt;
  } m_ent_t;

  m_ent_t        mq[$];
  bit            e_valid;
  logic [31:0]   e_pc, e_imm, e_v1, e_v2;
  logic [2:0]    e_flags;
  logic [TW-1:0] e_rob;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: oldest ready op leaves, waiting operands snoop the CDB, new op joins the tail
  task automatic model_step();
    int old_n;
    m_ent_t n;
`ifdef BRQ_PERF_CNT_EN
    if (rst) begin
      m_full = 0;
      m_iss  = 0;
    end else begin
      if (mq.size() == DEPTH) m_full++;
      if (e_valid) m_iss++;
    end
`endif
    if (rst) begin
      mq.delete();
      e_valid = 0; e_pc = 0; e_imm = 0; e_v1 = 0; e_v2 = 0; e_flags = 0; e_rob = 0;
      return;
    end
    old_n   = mq.size();
    e_valid = 0;
    if (!flush) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].r1 && mq[i].r2) begin
          e_valid = 1;
          e_pc = mq[i].pc; e_imm = mq[i].imm; e_v1 = mq[i].v1; e_v2 = mq[i].v2;
          e_flags = {mq[i].br, mq[i].jp, mq[i].pt};
          e_rob = mq[i].rob;
          mq.delete(i);
          break;
        end
      end
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].v1 = cdb_val; mq[i].r1 = 1; end
        if (!mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].v2 = cdb_val; mq[i].r2 = 1; end
      end
    end
    if (flush) begin
      mq.delete();
    end else if (disp_valid && old_n < DEPTH) begin
      n.pc = disp_pc; n.imm = disp_imm; n.v1 = disp_v1; n.v2 = disp_v2;
      n.t1 = disp_t1; n.t2 = disp_t2; n.rob = disp_rob;
      n.r1 = disp_r1; n.r2 = disp_r2; n.br = disp_br; n.jp = disp_jp; n.pt = disp_pt;
      if (cdb_valid && !n.r1 && n.t1 == cdb_tag) begin n.v1 = cdb_val; n.r1 = 1; end
      if (cdb_valid && !n.r2 && n.t2 == cdb_tag) begin n.v2 = cdb_val; n.r2 = 1; end
      mq.push_back(n);
    end
  endtask

  task automatic check_outputs();
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
    check_eq("iss_valid", 32'(iss_valid), 32'(e_valid));
    check_eq("iss_pc", iss_pc, e_pc);
    check_eq("iss_imm", iss_imm, e_imm);
    check_eq("iss_rs1_val", iss_v1, e_v1);
    check_eq("iss_rs2_val", iss_v2, e_v2);
    check_eq("iss_flags", 32'({iss_br, iss_jp, iss_pt}), 32'(e_flags));
    check_eq("iss_rob_tag", 32'(iss_rob), 32'(e_rob));
`ifdef BRQ_PERF_CNT_EN
    check_eq("perf_full", perf_full, m_full);
    check_eq("perf_issued", perf_iss, m_iss);
`endif
  endtask

  // Inputs are set at the falling edge; model and DUT both consume them at the next rising edge
  task automatic step_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    rst = 0; flush = 0; disp_valid = 0;
    disp_pc = 0; disp_imm = 0; disp_v1 = 0; disp_v2 = 0;
    disp_r1 = 0; disp_r2 = 0; disp_t1 = 0; disp_t2 = 0; disp_rob = 0;
    disp_br = 0; disp_jp = 0; disp_pt = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
  endtask

  task automatic set_disp(input logic [31:0] pc, input logic [31:0] imm,
                          input logic r1, input logic [TW-1:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [TW-1:0] t2, input logic [31:0] v2,
                          input logic [TW-1:0] rob);
    disp_valid = 1; disp_pc = pc; disp_imm = imm;
    disp_r1 = r1; disp_t1 = t1; disp_v1 = v1;
    disp_r2 = r2; disp_t2 = t2; disp_v2 = v2;
    disp_rob = rob; disp_br = 1; disp_jp = 0; disp_pt = 0;
  endtask

  task automatic rand_inputs();
    rst        = ($urandom_range(0, 199) == 0);
    flush      = ($urandom_range(0, 29) == 0);
    disp_valid = ($urandom_range(0, 9) < 6);
    disp_pc    = $urandom; disp_imm = $urandom;
    disp_v1    = $urandom; disp_v2 = $urandom;
    disp_r1    = ($urandom_range(0, 1) == 1);
    disp_r2    = ($urandom_range(0, 1) == 1);
    disp_t1    = TW'($urandom_range(0, 15));
    disp_t2    = TW'($urandom_range(0, 15));
    disp_rob   = TW'($urandom_range(0, 15));
    disp_jp    = ($urandom_range(0, 3) == 0);
    disp_br    = !disp_jp;
    disp_pt    = ($urandom_range(0, 1) == 1);
    if (disp_jp && $urandom_range(0, 1) == 1) begin
      disp_r1 = 1;
      disp_r2 = 1;
    end
    cdb_valid  = ($urandom_range(0, 1) == 1);
    cdb_tag    = TW'($urandom_range(0, 15));
    cdb_val    = $urandom;
  endtask

  initial begin
    set_idle();
    rst = 1;
    @(negedge clk);
    step_cycle();
    step_cycle();
    rst = 0;
    step_cycle();

    // Single ready BNE: issues two cycles after dispatch
    set_disp(32'h100, 32'h20, 1, 0, 32'h11, 1, 0, 32'h22, 4'd3);
    step_cycle();
    check_eq("t1_count_after_disp", 32'(count), 32'd1);
    check_eq("t1_no_early_issue", 32'(iss_valid), 32'd0);
    set_idle();
    step_cycle();
    check_eq("t1_valid", 32'(iss_valid), 32'd1);
    check_eq("t1_pc", iss_pc, 32'h100);
    check_eq("t1_imm", iss_imm, 32'h20);
    check_eq("t1_rob", 32'(iss_rob), 32'd3);
    check_eq("t1_count_empty", 32'(count), 32'd0);
    step_cycle();
    check_eq("t1_pulse", 32'(iss_valid), 32'd0);

    // Older waiting op is bypassed by a younger ready op, then woken by the CDB
    set_disp(32'h200, 32'h4, 0, 4'd5, 32'h0, 1, 0, 32'h9, 4'd6);
    step_cycle();
    set_disp(32'h300, 32'h8, 1, 0, 32'h1, 1, 0, 32'h2, 4'd7);
    step_cycle();
    set_idle();
    step_cycle();
    check_eq("t2_b_first", iss_pc, 32'h300);
    cdb_valid = 1; cdb_tag = 4'd5; cdb_val = 32'hDEAD;
    step_cycle();
    set_idle();
    step_cycle();
    check_eq("t2_a_valid", 32'(iss_valid), 32'd1);
    check_eq("t2_a_pc", iss_pc, 32'h200);
    check_eq("t2_a_rs1", iss_v1, 32'hDEAD);

    // Same-cycle CDB bypass on dispatch
    set_disp(32'h400, 32'hC, 1, 0, 32'h3, 0, 4'd7, 32'h0, 4'd8);
    cdb_valid = 1; cdb_tag = 4'd7; cdb_val = 32'h42;
    step_cycle();
    set_idle();
    step_cycle();
    check_eq("t3_valid", 32'(iss_valid), 32'd1);
    check_eq("t3_rs2", iss_v2, 32'h42);

    // Fill with waiting ops, reject one more, wake the oldest
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(32'h500 + 32'(i), 32'h0, 0, TW'(9 + i), 32'h0, 1, 0, 32'h0, TW'(i));
      step_cycle();
    end
    check_eq("t4_full_count", 32'(count), 32'd4);
    check_eq("t4_not_ready", 32'(disp_ready), 32'd0);
    set_disp(32'h999, 32'h0, 1, 0, 32'h0, 1, 0, 32'h0, 4'd15);
    step_cycle();
    check_eq("t4_reject_count", 32'(count), 32'd4);
    set_idle();
    cdb_valid = 1; cdb_tag = 4'd9; cdb_val = 32'h77;
    step_cycle();
    set_idle();
    step_cycle();
    check_eq("t4_wake_issue", iss_pc, 32'h500);
    check_eq("t4_ready_again", 32'(disp_ready), 32'd1);

    // Flush with three entries and a concurrent dispatch
    set_disp(32'hF00, 32'h0, 1, 0, 32'h0, 1, 0, 32'h0, 4'd1);
    flush = 1;
    step_cycle();
    check_eq("t5_count", 32'(count), 32'd0);
    check_eq("t5_no_issue", 32'(iss_valid), 32'd0);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check_eq("t5_dropped", 32'(iss_valid), 32'd0);
    end

    // Randomized traffic including rare flushes and resets
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_issue_queue.md
# branch_issue_queue

In-order-dispatch, out-of-order-issue scheduler that feeds the single branch execution unit. It buffers up to DEPTH branch/jump micro-ops from rename/dispatch and snoops the common data bus (CDB) for pending source operands. Each cycle it issues the oldest fully-ready entry to the branch unit and empties itself on a pipeline flush.

## Interface
- DEPTH, 4, number of queue entries (≥2)
- ROB_TAG_W, 4, ROB tag width; also the operand-producer tag width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  queue can accept this cycle
- disp_pc_i, disp_imm_i  in  32  branch PC, PC-relative offset
- disp_rs1_val_i, disp_rs2_val_i  in  32  operand value (meaningful when ready)
- disp_rs1_rdy_i, disp_rs2_rdy_i  in  1  operand already available
- disp_rs1_tag_i, disp_rs2_tag_i  in  ROB_TAG_W  producer tag when not ready
- disp_is_branch_i, disp_is_jump_i, disp_pred_taken_i  in  1  op class, prediction
- disp_rob_tag_i  in  ROB_TAG_W  ROB tag of the op
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  ROB_TAG_W  broadcast producer tag
- cdb_val_i  in  32  broadcast value
- flush_i  in  1  mispredict/exception flush; kills all entries
- iss_valid_o  out  1  issue to branch unit (drives its valid_i)
- iss_pc_o, iss_imm_o, iss_rs1_val_o, iss_rs2_val_o  out  32  issued fields
- iss_is_branch_o, iss_is_jump_o, iss_pred_taken_o  out  1  issued flags
- iss_rob_tag_o  out  ROB_TAG_W  issued ROB tag
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is a shifting (collapsing) queue: entry 0 is the oldest; younger entries occupy contiguous higher indices.
- Dispatch is accepted when disp_valid_i && disp_ready_o && !flush_i. disp_ready_o = (count_o < DEPTH). A slot freed by an issue in the same cycle is not reused that cycle.
- The new entry is written at index count_o, or count_o−1 if an issue collapses the queue in the same cycle.
- Wakeup: every valid entry with an operand not ready and tag == cdb_tag_i while cdb_valid_i captures cdb_val_i and sets that operand ready.
- Dispatch bypass: a dispatching operand that is not ready and whose tag matches the same-cycle CDB tag is written already ready, with cdb_val_i.
- Select: the lowest-index entry whose rs1 and rs2 are both ready (as registered at the start of the cycle) is issued. Its fields are registered into the iss_* outputs, and entries above it shift down by one.
- Jumps (is_jump) still wait on rs1 (JALR base); a JAL is dispatched with both operands marked ready.
- Flush: all entries are invalidated, count → 0, any same-cycle dispatch is dropped, and iss_valid_o is 0 in the following cycle.

## Timing
- Reset: all entries invalid; count_o=0, disp_ready_o=1, iss_valid_o=0, all iss_* data outputs 0.
- An entry dispatched ready in cycle N is selectable in N+1, and iss_valid_o is high in N+2.
- An operand woken by CDB in cycle N makes its entry selectable in N+1.
- Throughput is at most one issue per cycle, with no bubble between back-to-back ready entries.
- count_o updates the cycle after dispatch or issue; a simultaneous dispatch and issue leaves it unchanged.
- rst asserted mid-operation behaves as a flush plus clearing the iss_* outputs.
- iss_valid_o is a single-cycle pulse per issued op.

## Configuration
- BRQ_PERF_CNT_EN defined: adds outputs perf_full_cyc_o[31:0] and perf_issued_o[31:0].
  - perf_full_cyc_o counts cycles with count_o==DEPTH.
  - perf_issued_o counts iss_valid_o pulses.
  - Both counters wrap at 2^32, are reset by rst, and are not cleared by flush_i.
- BRQ_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- brq_pkg holds the brq_entry_t struct (valid, pc, imm, rs1/rs2 val/tag/rdy, is_branch, is_jump, pred_taken, rob_tag) and a CNT_W localparam function.
- Sub-module brq_select is a combinational oldest-ready picker (DEPTH-bit ready vector in; one-hot grant and index out).

## Test plan
- Reset then dispatch one ready BNE (pc=0x100, imm=0x20, tag 3) → iss_valid_o=1 exactly two cycles later with iss_pc_o=0x100, iss_imm_o=0x20, iss_rob_tag_o=3, then count_o=0.
- Dispatch A (rs1 waiting on tag 5), then B (ready) → B issues first; CDB tag 5 with value 0xDEAD → A issues two cycles later with iss_rs1_val_o=0xDEAD.
- Dispatch with rs2 tag 7 while the same-cycle CDB has tag 7, value 0x42 → no stall, issue after two cycles with iss_rs2_val_o=0x42.
- Fill 4 non-ready entries → disp_ready_o=0 and count_o=4; a dispatch attempt is ignored; waking entry 0 → disp_ready_o=1 the cycle after issue.
- Queue holding 3 entries, flush_i with a concurrent dispatch → count_o=0 the next cycle, no iss_valid_o, and the dispatched op is never issued.
- With BRQ_PERF_CNT_EN: hold the queue full for 10 cycles and issue 4 ops → perf_full_cyc_o=10, perf_issued_o=4.
